ptp_event_capture: RTL and testbench

PTP_EVENT_CAPTURE -- requirements
Module: ptp_event_capture

---
 rtl/ptp_event_capture.sv | 129 ++++++++++++
 tb/tb_ptp_event_capture.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/ptp_event_capture.sv
// PTP event timestamp capture: free-running time counter, rising-edge
// detection on MAC TX/RX event strobes, and a capture FIFO of
// {event mask, timestamp} entries with overflow tracking.
module ptp_event_capture #(
  parameter int          TS_WIDTH   = 64,
  parameter int          TS_INCR    = 8,
  parameter int          FIFO_DEPTH = 16,
  parameter logic [9:0]  EVT_EN     = 10'h3FF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic                          ts_load,
  input  logic [TS_WIDTH-1:0]           ts_load_value,
  output logic [TS_WIDTH-1:0]           ts_now,
  input  logic [4:0]                    evt_tx,
  input  logic [4:0]                    evt_rx,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [9:0]                    m_mask,
  output logic [TS_WIDTH-1:0]           m_ts,
  output logic [$clog2(FIFO_DEPTH):0]   fill_level,
  output logic                          overflow,
  input  logic                          overflow_clr,
  output logic [15:0]                   drop_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = 10 + TS_WIDTH;

  logic [TS_WIDTH-1:0] ts_q, ts_d;
  logic [9:0]          evt_cur, evt_prev_q, fired;
  logic                push, pop, full, accept, drop;
  logic [EW-1:0]       mem_q [FIFO_DEPTH];
  logic [EW-1:0]       head;
  logic [AW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]       count_q, count_d;
  logic                overflow_q, overflow_d;
  logic [15:0]         drop_cnt_q, drop_cnt_d;

  // Counter next state: a load overrides the increment; wrap is silent.
  always_comb begin
    ts_d = ts_q + TS_WIDTH'(TS_INCR);
    if (ts_load) ts_d = ts_load_value;
  end

  // Time counter register.
  always_ff @(posedge clk) begin
    if (rst) ts_q <= '0;
    else     ts_q <= ts_d;
  end

  assign evt_cur = {evt_rx, evt_tx};
  assign fired   = evt_cur & ~evt_prev_q & EVT_EN;

  // Edge-detect history; all-ones at reset so levels already high never fire.
  // Updates even while disabled so a held level does not fire on re-enable.
  always_ff @(posedge clk) begin
    if (rst) evt_prev_q <= '1;
    else     evt_prev_q <= evt_cur;
  end

  assign m_valid = (count_q != '0);
  assign full    = (count_q == CW'(FIFO_DEPTH));
  assign push    = enable && (|fired);
  assign pop     = m_valid && m_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign accept  = push && (!full || pop);
  assign drop    = push && full && !pop;

  // Capture storage; the entry carries the pre-load counter value.
  always_ff @(posedge clk) begin
    if (!rst && accept) mem_q[wr_ptr_q] <= {fired, ts_q};
  end

  // Occupancy next state.
  always_comb begin
    count_d = count_q;
    case ({accept, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO pointers and occupancy; reset discards every held entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (accept) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)    rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  // Drop tracking: a drop wins over a same-cycle clear; the count saturates.
  always_comb begin
    overflow_d = overflow_q;
    if (overflow_clr) overflow_d = 1'b0;
    if (drop)         overflow_d = 1'b1;
    drop_cnt_d = drop_cnt_q;
    if (drop && drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
  end

  // Overflow flag and drop counter registers; only rst clears the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Head data is forced to zero when empty so stale storage never shows.
  assign head       = mem_q[rd_ptr_q];
  assign m_mask     = m_valid ? head[EW-1 -: 10] : '0;
  assign m_ts       = m_valid ? head[TS_WIDTH-1:0] : '0;
  assign ts_now     = ts_q;
  assign fill_level = count_q;
  assign overflow   = overflow_q;
  assign drop_count = drop_cnt_q;

endmodule

// File: tb/tb_ptp_event_capture.sv
// Self-checking bench: a reference model of the counter and edge detector
// pushes expected entries into a scoreboard queue; the head is compared
// every cycle it is valid and popped on each handshake.
module tb_ptp_event_capture;
  localparam int TS_WIDTH   = 64;
  localparam int TS_INCR    = 8;
  localparam int FIFO_DEPTH = 16;
  localparam int FW         = $clog2(FIFO_DEPTH) + 1;

  logic                clk, rst, enable, ts_load, m_ready, overflow_clr;
  logic [TS_WIDTH-1:0] ts_load_value, ts_now, m_ts;
  logic [4:0]          evt_tx, evt_rx;
  logic                m_valid, overflow;
  logic [9:0]          m_mask;
  logic [FW-1:0]       fill_level;
  logic [15:0]         drop_count;

  ptp_event_capture #(
    .TS_WIDTH(TS_WIDTH), .TS_INCR(TS_INCR), .FIFO_DEPTH(FIFO_DEPTH), .EVT_EN(10'h3FF)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .ts_load(ts_load),
    .ts_load_value(ts_load_value), .ts_now(ts_now), .evt_tx(evt_tx), .evt_rx(evt_rx),
    .m_valid(m_valid), .m_ready(m_ready), .m_mask(m_mask), .m_ts(m_ts),
    .fill_level(fill_level), .overflow(overflow), .overflow_clr(overflow_clr),
    .drop_count(drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk, n_fail;

  // Model state
  logic [TS_WIDTH-1:0]      mdl_ts;
  logic [9:0]               mdl_prev;
  logic [TS_WIDTH+9:0]      sb[$];
  logic                     mdl_ovf;
  logic [15:0]              mdl_drop;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic mdl_reset();
    mdl_ts = '0; mdl_prev = '1; sb.delete(); mdl_ovf = 1'b0; mdl_drop = '0;
  endtask

  // Check outputs against the model, advance the model over one clock
  // edge using the currently driven inputs, then cross the edge.
  task automatic step();
    logic [9:0] cur, fired;
    logic       pop;
    chk("ts_now", ts_now, mdl_ts);
    chk("fill_level", fill_level, sb.size());
    chk("m_valid", m_valid, sb.size() != 0);
    chk("overflow", overflow, mdl_ovf);
    chk("drop_count", drop_count, mdl_drop);
    if (sb.size() != 0) begin
      chk("head_mask", m_mask, sb[0][TS_WIDTH+9:TS_WIDTH]);
      chk("head_ts", m_ts, sb[0][TS_WIDTH-1:0]);
    end
    if (rst) mdl_reset();
    else begin
      pop = (sb.size() != 0) && m_ready;
      if (pop) void'(sb.pop_front());
      cur   = {evt_rx, evt_tx};
      fired = cur & ~mdl_prev;
      mdl_prev = cur;
      if (overflow_clr) mdl_ovf = 1'b0;
      if (enable && fired != 0) begin
        if (sb.size() < FIFO_DEPTH) sb.push_back({fired, mdl_ts});
        else begin
          mdl_ovf = 1'b1;
          if (mdl_drop != 16'hFFFF) mdl_drop++;
        end
      end
      mdl_ts = ts_load ? ts_load_value : mdl_ts + TS_WIDTH'(TS_INCR);
    end
    @(posedge clk); #1;
  endtask

  logic [TS_WIDTH-1:0] pre_ts;

  initial begin
    n_chk = 0; n_fail = 0;
    rst = 1'b1; enable = 1'b1; ts_load = 1'b0; ts_load_value = '0;
    evt_tx = '0; evt_rx = '0; m_ready = 1'b0; overflow_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    mdl_reset();
    // Reset state
    chk("rst_ts", ts_now, 0);
    chk("rst_valid", m_valid, 0);
    chk("rst_fill", fill_level, 0);
    chk("rst_mask", m_mask, 0);
    chk("rst_mts", m_ts, 0);
    // Level high at reset release must not fire
    evt_rx[2] = 1'b1;
    rst = 1'b0;

    // Single edge at ts_now = 0x40
    for (int i = 0; i < 20 && mdl_ts != 64'h40; i++) step();
    evt_rx[2] = 1'b0;
    evt_tx[4] = 1'b1;
    step();
    chk("single_valid", m_valid, 1);
    chk("single_mask", m_mask, 10'h010);
    chk("single_ts", m_ts, 64'h40);
    evt_tx[4] = 1'b0; m_ready = 1'b1;
    step();
    m_ready = 1'b0;

    // Simultaneous edges -> one entry
    evt_tx[0] = 1'b1; evt_rx[0] = 1'b1;
    step();
    evt_tx[0] = 1'b0; evt_rx[0] = 1'b0;
    chk("simul_fill", fill_level, 1);
    chk("simul_mask", m_mask, 10'h021);
    m_ready = 1'b1; step(); m_ready = 1'b0;

    // Disabled edge held across re-enable does not fire
    enable = 1'b0; evt_rx[3] = 1'b1; step();
    enable = 1'b1; step(); step();
    chk("reenable_fill", fill_level, 0);
    evt_rx[3] = 1'b0;

    // Overflow: FIFO_DEPTH+3 edges with no consumer
    for (int i = 0; i < FIFO_DEPTH + 3; i++) begin
      evt_tx[1] = 1'b1; step();
      evt_tx[1] = 1'b0; step();
    end
    chk("ovf_fill", fill_level, FIFO_DEPTH);
    chk("ovf_drop", drop_count, 3);
    chk("ovf_flag", overflow, 1);
    overflow_clr = 1'b1; step(); overflow_clr = 1'b0;
    chk("clr_flag", overflow, 0);
    chk("clr_drop", drop_count, 3);

    // Full with simultaneous pop: push accepted, no drop
    m_ready = 1'b1; evt_tx[1] = 1'b1; step(); evt_tx[1] = 1'b0;
    chk("fullpop_fill", fill_level, FIFO_DEPTH);
    chk("fullpop_drop", drop_count, 3);
    for (int i = 0; i < 3 * FIFO_DEPTH && sb.size() != 0; i++) step();
    chk("drained", fill_level, 0);
    m_ready = 1'b0;

    // Load and wrap
    ts_load = 1'b1; ts_load_value = 64'hFFFF_FFFF_FFFF_FFFC; step();
    ts_load = 1'b0; step();
    chk("wrap", ts_now, 64'h4);

    // Capture in a load cycle uses the pre-load value
    pre_ts = mdl_ts;
    ts_load = 1'b1; ts_load_value = 64'h1000; evt_tx[2] = 1'b1; step();
    ts_load = 1'b0; evt_tx[2] = 1'b0;
    chk("load_cap_ts", m_ts, pre_ts);
    chk("load_now", ts_now, 64'h1000);
    m_ready = 1'b1; step();

    // Random back-pressure and events
    for (int i = 0; i < 200; i++) begin
      m_ready = 1'($urandom_range(0, 1));
      enable  = ($urandom_range(0, 7) != 0);
      evt_tx  = 5'($urandom) & 5'($urandom);
      evt_rx  = 5'($urandom) & 5'($urandom);
      overflow_clr = ($urandom_range(0, 15) == 0);
      step();
    end
    evt_tx = '0; evt_rx = '0; enable = 1'b1; overflow_clr = 1'b0; m_ready = 1'b1;
    for (int i = 0; i < 3 * FIFO_DEPTH && sb.size() != 0; i++) step();
    chk("rand_drained", fill_level, 0);

    // Reset while five entries are held
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      evt_rx[4] = 1'b1; step();
      evt_rx[4] = 1'b0; step();
    end
    chk("pre_rst_fill", fill_level, 5);
    rst = 1'b1; evt_tx[3] = 1'b1; ts_load = 1'b1; m_ready = 1'b1; step();
    chk("rst_mid_valid", m_valid, 0);
    chk("rst_mid_fill", fill_level, 0);
    chk("rst_mid_ts", ts_now, 0);
    chk("rst_mid_drop", drop_count, 0);
    rst = 1'b0; ts_load = 1'b0; step(); step();
    chk("post_rst_fill", fill_level, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
